full_adder: RTL and testbench
=============================

FULL_ADDER -- requirements
Module: full_adder

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the statistics counters (used only under FULL_ADDER_STATS_EN).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-004 SHALL have port Ai, input, 1, addend A.
REQ-005 SHALL have port Bi, input, 1, addend B.
REQ-006 SHALL have port Cini, input, 1, carry-in.
REQ-007 SHALL have port en, input, 1, capture strobe for the registered result.
REQ-008 SHALL have port Di, output, 1, combinational sum bit.
REQ-009 SHALL have port Couti, output, 1, combinational carry-out.
REQ-010 SHALL have port Di_q, output, 1, registered sum.
REQ-011 SHALL have port Couti_q, output, 1, registered carry-out.
REQ-012 SHALL have port q_valid, output, 1, high when Di_q/Couti_q hold a captured result.
REQ-013 SHALL have port op_count, output, CNT_W, count of captures; present only with FULL_ADDER_STATS_EN.
REQ-014 SHALL have port carry_count, output, CNT_W, count of captures with Couti=1; present only with FULL_ADDER_STATS_EN.

Function
REQ-015 SHALL drive Di = Ai XOR Bi XOR Cini, purely combinational, zero clock latency, independent of clk, rst, en.
REQ-016 SHALL drive Couti = majority(Ai,Bi,Cini) = (Ai&Bi)|(Ai&Cini)|(Bi&Cini), combinational, independent of clk, rst, en.
REQ-017 SHALL make {Couti,Di} equal the 2-bit arithmetic sum Ai+Bi+Cini for all 8 input combinations; outputs never X/Z for 0/1 inputs.
REQ-018 SHALL, on a rising clk edge with rst=0 and en=1, load Di_q<=Di, Couti_q<=Couti, q_valid<=1 (one-cycle latency).
REQ-019 SHALL, on a rising edge with rst=0 and en=0, hold Di_q, Couti_q, q_valid unchanged.
REQ-020 SHALL treat inputs changing while en=0 as not affecting registered outputs.
REQ-021 SHALL, with FULL_ADDER_STATS_EN, increment op_count by 1 per capture and carry_count by 1 per capture with Couti=1, same edge.
REQ-022 SHALL wrap both counters from 2^CNT_W-1 to 0 without saturation or flag.

Reset
REQ-023 SHALL, on a rising edge with rst=1, set Di_q=0, Couti_q=0, q_valid=0, op_count=0, carry_count=0.
REQ-024 SHALL give rst priority over en on the same edge; no capture or count occurs.
REQ-025 SHALL NOT let rst affect Di/Couti; combinational outputs stay valid during reset.
REQ-026 SHALL, when rst is asserted mid-operation, discard the held result; the first capture after deassertion proceeds normally.

Configuration
REQ-027 SHALL compile op_count, carry_count and their logic only when macro FULL_ADDER_STATS_EN is defined.
REQ-028 SHALL, without FULL_ADDER_STATS_EN, omit those ports and counters entirely; all other behaviour identical.

Verification
REQ-029 SHALL cover exhaustive sweep i=0..7 of {Ai,Bi,Cini}=i, settle 5 ns, no clock -> Di=parity(i), Couti=1 for i in {3,5,6,7}, else 0.
REQ-030 SHALL cover rst=1 for 2 edges, then release -> Di_q=0, Couti_q=0, q_valid=0, counters 0, while Di/Couti track inputs.
REQ-031 SHALL cover inputs 1,1,1 with en=1 for one edge -> next cycle Di_q=1, Couti_q=1, q_valid=1; then inputs 0,0,0 with en=0 -> Di_q/Couti_q still 1.
REQ-032 SHALL cover rst=1 and en=1 on the same edge with inputs 1,1,0 -> Di_q=0, Couti_q=0, q_valid=0, counts unchanged at 0.
REQ-033 SHALL cover, with FULL_ADDER_STATS_EN, eight captures of i=0..7 -> op_count=8, carry_count=4.
REQ-034 SHALL cover, with CNT_W=4 and FULL_ADDER_STATS_EN, 17 captures -> op_count wraps to 1.

Source files
------------

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//   One-bit full adder. Di/Couti are purely combinational. Di_q/Couti_q/q_valid
//   hold the sum and carry captured on the last enabled clock edge.
//   With FULL_ADDER_STATS_EN defined, two wrapping CNT_W-bit counters are added:
//   one counts captures and one counts captures whose carry-out was 1.
//
//   Optional feature macro: FULL_ADDER_STATS_EN
//
// Ports
//   clk         in   clock; all state updates on the rising edge
//   rst         in   synchronous active-high reset; takes priority over en
//   Ai, Bi      in   addends
//   Cini        in   carry-in
//   en          in   capture strobe for the registered result
//   Di          out  combinational sum bit
//   Couti       out  combinational carry-out
//   Di_q        out  registered sum
//   Couti_q     out  registered carry-out
//   q_valid     out  high once a result has been captured since reset
//   op_count    out  capture count            (FULL_ADDER_STATS_EN only)
//   carry_count out  count of carry captures  (FULL_ADDER_STATS_EN only)
// -----------------------------------------------------------------------------
module full_adder #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Ai,
  input  logic             Bi,
  input  logic             Cini,
  input  logic             en,
  output logic             Di,
  output logic             Couti,
  output logic             Di_q,
  output logic             Couti_q,
  output logic             q_valid
`ifdef FULL_ADDER_STATS_EN
  ,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] carry_count
`endif
);

  // Combinational sum and carry; never gated by clk, rst or en.
  assign Di    = Ai ^ Bi ^ Cini;
  assign Couti = (Ai & Bi) | (Ai & Cini) | (Bi & Cini);

  logic sum_q,   sum_d;
  logic carry_q, carry_d;
  logic valid_q, valid_d;

  // Result capture: load on en, otherwise hold.
  always_comb begin
    sum_d   = sum_q;
    carry_d = carry_q;
    valid_d = valid_q;
    if (en) begin
      sum_d   = Di;
      carry_d = Couti;
      valid_d = 1'b1;
    end
  end

  // Result registers; reset wins over a same-edge capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= 1'b0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
    end
  end

  assign Di_q    = sum_q;
  assign Couti_q = carry_q;
  assign q_valid = valid_q;

`ifdef FULL_ADDER_STATS_EN
  logic [CNT_W-1:0] op_cnt_q,    op_cnt_d;
  logic [CNT_W-1:0] carry_cnt_q, carry_cnt_d;

  // Statistics: both counters wrap naturally at 2^CNT_W.
  always_comb begin
    op_cnt_d    = op_cnt_q;
    carry_cnt_d = carry_cnt_q;
    if (en) begin
      op_cnt_d = op_cnt_q + CNT_W'(1);
      if (Couti) begin
        carry_cnt_d = carry_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_cnt_q    <= '0;
      carry_cnt_q <= '0;
    end else begin
      op_cnt_q    <= op_cnt_d;
      carry_cnt_q <= carry_cnt_d;
    end
  end

  assign op_count    = op_cnt_q;
  assign carry_count = carry_cnt_q;
`else
  // CNT_W only sizes the counters; this empty block keeps it referenced.
  if (CNT_W == 0) begin : g_no_stats
  end
`endif

endmodule

// File: tb/tb_full_adder.sv
// -----------------------------------------------------------------------------
// tb_full_adder
//   Directed-vector bench for full_adder with a queue-based scoreboard. The
//   stimulus process pushes the expected outputs and signals the monitor,
//   which pops each entry and compares it against the DUT outputs.
//   Expected sum/carry come from hand-written 8-entry truth tables.
// -----------------------------------------------------------------------------
module tb_full_adder;

  localparam int unsigned CW = 4;

  logic clk;
  logic rst;
  logic ai, bi, ci, en;
  logic d, cout, dq, coutq, qv;
`ifdef FULL_ADDER_STATS_EN
  logic [CW-1:0] opc, cyc;
`endif

  full_adder #(.CNT_W(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .Ai      (ai),
    .Bi      (bi),
    .Cini    (ci),
    .en      (en),
    .Di      (d),
    .Couti   (cout),
    .Di_q    (dq),
    .Couti_q (coutq),
    .q_valid (qv)
`ifdef FULL_ADDER_STATS_EN
    ,
    .op_count    (opc),
    .carry_count (cyc)
`endif
  );

  // Hand-computed truth tables indexed by {A,B,Cin}.
  // sum  : i=0..7 -> 0,1,1,0,1,0,0,1
  // carry: i=0..7 -> 0,0,0,1,0,1,1,1
  logic [7:0] sum_tab   = 8'b1001_0110;
  logic [7:0] carry_tab = 8'b1110_1000;

  typedef struct {
    string         name;
    logic          d;
    logic          c;
    logic          dq;
    logic          cq;
    logic          v;
    logic [CW-1:0] op;
    logic [CW-1:0] cy;
  } exp_t;

  exp_t sb[$];
  event chk_ev;
  int   checks = 0;
  int   errors = 0;

  // Reference state of the registered outputs.
  logic          m_dq, m_cq, m_v;
  logic [CW-1:0] m_op, m_cy;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // Monitor: pops every pending expectation and compares to the DUT.
  initial begin
    forever begin
      @(chk_ev);
      while (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if ({d, cout, dq, coutq, qv} !== {e.d, e.c, e.dq, e.cq, e.v}) begin
          errors++;
          $display("FAIL %s: got D=%b C=%b Dq=%b Cq=%b V=%b required D=%b C=%b Dq=%b Cq=%b V=%b",
                   e.name, d, cout, dq, coutq, qv, e.d, e.c, e.dq, e.cq, e.v);
        end
`ifdef FULL_ADDER_STATS_EN
        checks++;
        if ({opc, cyc} !== {e.op, e.cy}) begin
          errors++;
          $display("FAIL %s_cnt: got op=%0d carry=%0d required op=%0d carry=%0d",
                   e.name, opc, cyc, e.op, e.cy);
        end
`endif
      end
    end
  end

  task automatic expect_now(input string nm);
    exp_t e;
    logic [2:0] idx;
    idx  = {ai, bi, ci};
    e.name = nm;
    e.d    = sum_tab[idx];
    e.c    = carry_tab[idx];
    e.dq   = m_dq;
    e.cq   = m_cq;
    e.v    = m_v;
    e.op   = m_op;
    e.cy   = m_cy;
    sb.push_back(e);
    ->chk_ev;
    #1;
  endtask

  task automatic model_reset();
    m_dq = 1'b0;
    m_cq = 1'b0;
    m_v  = 1'b0;
    m_op = '0;
    m_cy = '0;
  endtask

  // One clock edge with the given inputs and strobes; updates the reference.
  task automatic clock_edge(input logic [2:0] abc, input logic e_in, input logic r_in);
    logic [2:0] idx;
    {ai, bi, ci} = abc;
    en  = e_in;
    rst = r_in;
    idx = abc;
    @(posedge clk);
    #1;
    if (r_in) begin
      model_reset();
    end else if (e_in) begin
      m_dq = sum_tab[idx];
      m_cq = carry_tab[idx];
      m_v  = 1'b1;
      m_op = m_op + CW'(1);
      if (carry_tab[idx]) m_cy = m_cy + CW'(1);
    end
    en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; {ai, bi, ci} = 3'b000;
    model_reset();

    // Reset held for two edges; combinational path tracks inputs throughout.
    clock_edge(3'b101, 1'b0, 1'b1);
    expect_now("rst_edge1");
    clock_edge(3'b011, 1'b0, 1'b1);
    expect_now("rst_edge2");
    rst = 1'b0;
    expect_now("rst_release");

    // Exhaustive combinational sweep with en low.
    for (int i = 0; i < 8; i++) begin
      {ai, bi, ci} = 3'(i);
      #5;
      expect_now($sformatf("sweep_%0d", i));
    end

    // Capture 1+1+1, then change inputs with en low: registers hold.
    clock_edge(3'b111, 1'b1, 1'b0);
    expect_now("cap_111");
    clock_edge(3'b000, 1'b0, 1'b0);
    expect_now("hold_000");
    clock_edge(3'b010, 1'b0, 1'b0);
    expect_now("hold_010");

    // Reset and enable on the same edge: reset wins.
    clock_edge(3'b110, 1'b1, 1'b1);
    expect_now("rst_over_en");

    // Eight captures i=0..7: op=8, carry=4.
    for (int i = 0; i < 8; i++) begin
      clock_edge(3'(i), 1'b1, 1'b0);
      expect_now($sformatf("cap_%0d", i));
    end

    // Nine more captures: op wraps 16 -> 0 and reaches 1 at 17.
    for (int i = 0; i < 9; i++) begin
      clock_edge(3'(i % 8), 1'b1, 1'b0);
      expect_now($sformatf("wrap_%0d", i));
    end

    // Mid-operation reset discards the result; next capture is normal.
    clock_edge(3'b111, 1'b0, 1'b1);
    expect_now("mid_rst");
    clock_edge(3'b100, 1'b1, 1'b0);
    expect_now("cap_after_rst");

    #2;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
